// File: rtl/expr_parser_n.sv
// expr_parser_n: turns a stream of decoded key tokens (digits and operator
// codes) into two unsigned operands and one operator for the ALU. The result
// is handed over on a valid/ready handshake. Overflow, syntax and bad-digit
// errors are reported through a sticky err flag that only OP_CLR clears.
module expr_parser_n #(
   parameter int              W       = 16,
   parameter int              MAX_DIG = 5,
   parameter int              OP_W    = 4,
   parameter logic [OP_W-1:0] OP_EQ   = 4'hF,
   parameter logic [OP_W-1:0] OP_CLR  = 4'hE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      digit_i,
   input  logic            digit_vld,
   input  logic [OP_W-1:0] op_i,
   input  logic            op_vld,
   output logic [W-1:0]    operand_a,
   output logic [W-1:0]    operand_b,
   output logic [OP_W-1:0] operation,
   output logic            res_vld,
   input  logic            res_rdy,
   output logic            busy,
   output logic            err,
   output logic [1:0]      err_code
);

   localparam int CNT_W = $clog2(MAX_DIG + 1);

   typedef enum logic [2:0] {
      A_FIRST = 3'd0,
      A_NUM   = 3'd1,
      B_FIRST = 3'd2,
      B_NUM   = 3'd3,
      HOLD    = 3'd4,
      ERR     = 3'd5
   } state_t;

   localparam logic [1:0] CODE_OVF = 2'b01;
   localparam logic [1:0] CODE_SYN = 2'b10;
   localparam logic [1:0] CODE_DIG = 2'b11;

   state_t            state_q, state_d;
   logic [W-1:0]      acc_a_q, acc_a_d;
   logic [W-1:0]      acc_b_q, acc_b_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              res_vld_q, res_vld_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;

   logic              digit_tok;
   logic              op_tok;
   logic              bad_digit;
   logic [W-1:0]      acc_sel;
   logic [W+3:0]      acc_ext;
   logic              acc_ovf;

   // Token arbitration and the shared multiply-accumulate datapath.
   // A digit always wins over a simultaneous operator; acc*10+digit is
   // formed 4 bits wider than the operand so overflow shows up in the top bits.
   always_comb begin
      digit_tok = digit_vld;
      op_tok    = op_vld && !digit_vld;
      bad_digit = digit_i > 4'd9;
      acc_sel   = (state_q == B_NUM) ? acc_b_q : acc_a_q;
      acc_ext   = ({4'b0000, acc_sel} * (W+4)'(10)) + {{W{1'b0}}, digit_i};
      acc_ovf   = acc_ext[W+3:W] != 4'b0000;
   end

   // Next-state logic for the token parser; status outputs follow state_d so
   // they appear registered one cycle after the token that caused them.
   always_comb begin
      state_d    = state_q;
      acc_a_d    = acc_a_q;
      acc_b_d    = acc_b_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      err_code_d = err_code_q;

      case (state_q)
         A_FIRST, B_FIRST: begin
            if (digit_tok) begin
               if (bad_digit) begin
                  state_d    = ERR;
                  err_code_d = CODE_DIG;
               end else begin
                  if (state_q == A_FIRST) begin
                     acc_a_d = {{(W-4){1'b0}}, digit_i};
                     state_d = A_NUM;
                  end else begin
                     acc_b_d = {{(W-4){1'b0}}, digit_i};
                     state_d = B_NUM;
                  end
                  cnt_d = CNT_W'(1);
               end
            end else if (op_tok) begin
               if (op_i == OP_CLR) begin
                  state_d    = A_FIRST;
                  acc_a_d    = '0;
                  acc_b_d    = '0;
                  cnt_d      = '0;
                  err_code_d = 2'b00;
               end else begin
                  state_d    = ERR;
                  err_code_d = CODE_SYN;
               end
            end
         end
         A_NUM, B_NUM: begin
            if (digit_tok) begin
               if (bad_digit) begin
                  state_d    = ERR;
                  err_code_d = CODE_DIG;
               end else if (cnt_q < CNT_W'(MAX_DIG)) begin
                  if (acc_ovf) begin
                     state_d    = ERR;
                     err_code_d = CODE_OVF;
                  end else begin
                     if (state_q == A_NUM) acc_a_d = acc_ext[W-1:0];
                     else                  acc_b_d = acc_ext[W-1:0];
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end else if (op_tok) begin
               if (op_i == OP_CLR) begin
                  state_d    = A_FIRST;
                  acc_a_d    = '0;
                  acc_b_d    = '0;
                  cnt_d      = '0;
                  err_code_d = 2'b00;
               end else if (state_q == A_NUM) begin
                  if (op_i == OP_EQ) begin
                     state_d    = ERR;
                     err_code_d = CODE_SYN;
                  end else begin
                     op_d    = op_i;
                     cnt_d   = '0;
                     state_d = B_FIRST;
                  end
               end else begin
                  if (op_i == OP_EQ) begin
                     state_d = HOLD;
                  end else begin
                     state_d    = ERR;
                     err_code_d = CODE_SYN;
                  end
               end
            end
         end
         HOLD: begin
            if (res_vld_q && res_rdy) begin
               state_d = A_FIRST;
               cnt_d   = '0;
            end
         end
         ERR: begin
            if (op_tok && op_i == OP_CLR) begin
               state_d    = A_FIRST;
               acc_a_d    = '0;
               acc_b_d    = '0;
               cnt_d      = '0;
               err_code_d = 2'b00;
            end
         end
         default: begin
            state_d = A_FIRST;
         end
      endcase

      res_vld_d = (state_d == HOLD);
      busy_d    = (state_d == HOLD);
      err_d     = (state_d == ERR);
   end

   // State and output registers; reset discards any partial expression at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= A_FIRST;
         acc_a_q    <= '0;
         acc_b_q    <= '0;
         cnt_q      <= '0;
         op_q       <= '0;
         res_vld_q  <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         acc_a_q    <= acc_a_d;
         acc_b_q    <= acc_b_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         res_vld_q  <= res_vld_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign operand_a = acc_a_q;
   assign operand_b = acc_b_q;
   assign operation = op_q;
   assign res_vld   = res_vld_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_expr_parser_n.sv
// tb_expr_parser_n: directed-vector bench for expr_parser_n with
// hand-computed expectations checked by immediate assertions.
module tb_expr_parser_n;

   logic        clk;
   logic        rst;
   logic [3:0]  digit_i;
   logic        digit_vld;
   logic [3:0]  op_i;
   logic        op_vld;
   logic [15:0] operand_a;
   logic [15:0] operand_b;
   logic [3:0]  operation;
   logic        res_vld;
   logic        res_rdy;
   logic        busy;
   logic        err;
   logic [1:0]  err_code;

   int errors = 0;
   int checks = 0;

   expr_parser_n dut (
      .clk       (clk),
      .rst       (rst),
      .digit_i   (digit_i),
      .digit_vld (digit_vld),
      .op_i      (op_i),
      .op_vld    (op_vld),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .operation (operation),
      .res_vld   (res_vld),
      .res_rdy   (res_rdy),
      .busy      (busy),
      .err       (err),
      .err_code  (err_code)
   );

   // 10-unit clock period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Present one token for one clock edge, return 1 unit after the edge
   task automatic applyStimulus(input logic dv, input logic [3:0] d, input logic ov, input logic [3:0] o);
      digit_vld = dv;
      digit_i   = d;
      op_vld    = ov;
      op_i      = o;
      @(posedge clk);
      #1;
      digit_vld = 1'b0;
      op_vld    = 1'b0;
   endtask

   task automatic sendDigit(input logic [3:0] d);
      applyStimulus(1'b1, d, 1'b0, 4'h0);
   endtask

   task automatic sendOp(input logic [3:0] o);
      applyStimulus(1'b0, 4'h0, 1'b1, o);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
   endtask

   // Clear from an error, then run 1 op1 2 = and expect a clean 1/2 result
   task automatic recoverCheck(input string tag);
      sendOp(4'hE);
      checkOutput({tag, "_clr_err"}, 32'(err), 32'd0);
      checkOutput({tag, "_clr_code"}, 32'(err_code), 32'd0);
      sendDigit(4'd1);
      sendOp(4'h1);
      sendDigit(4'd2);
      sendOp(4'hF);
      checkOutput({tag, "_rec_vld"}, 32'(res_vld), 32'd1);
      checkOutput({tag, "_rec_a"}, 32'(operand_a), 32'd1);
      checkOutput({tag, "_rec_b"}, 32'(operand_b), 32'd2);
      idle();
   endtask

   initial begin
      rst       = 1'b1;
      digit_i   = 4'h0;
      digit_vld = 1'b0;
      op_i      = 4'h0;
      op_vld    = 1'b0;
      res_rdy   = 1'b1;
      #12;
      checkOutput("rst_a", 32'(operand_a), 32'd0);
      checkOutput("rst_vld", 32'(res_vld), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_code", 32'(err_code), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Normal expression 12 op1 34 =
      sendDigit(4'd1);
      sendDigit(4'd2);
      sendOp(4'h1);
      sendDigit(4'd3);
      sendDigit(4'd4);
      checkOutput("norm_pre_vld", 32'(res_vld), 32'd0);
      sendOp(4'hF);
      checkOutput("norm_vld", 32'(res_vld), 32'd1);
      checkOutput("norm_busy", 32'(busy), 32'd1);
      checkOutput("norm_a", 32'(operand_a), 32'd12);
      checkOutput("norm_b", 32'(operand_b), 32'd34);
      checkOutput("norm_op", 32'(operation), 32'd1);
      checkOutput("norm_err", 32'(err), 32'd0);
      idle();
      checkOutput("norm_vld_drop", 32'(res_vld), 32'd0);
      checkOutput("norm_busy_drop", 32'(busy), 32'd0);

      // Backpressure: 7 op2 5 = held with res_rdy low, digit 9 ignored in HOLD
      res_rdy = 1'b0;
      sendDigit(4'd7);
      sendOp(4'h2);
      sendDigit(4'd5);
      sendOp(4'hF);
      checkOutput("bp_vld1", 32'(res_vld), 32'd1);
      sendDigit(4'd9);
      checkOutput("bp_vld2", 32'(res_vld), 32'd1);
      checkOutput("bp_a_hold", 32'(operand_a), 32'd7);
      idle();
      checkOutput("bp_busy3", 32'(busy), 32'd1);
      checkOutput("bp_b_hold", 32'(operand_b), 32'd5);
      checkOutput("bp_op_hold", 32'(operation), 32'd2);
      res_rdy = 1'b1;
      idle();
      checkOutput("bp_vld_drop", 32'(res_vld), 32'd0);
      checkOutput("bp_busy_drop", 32'(busy), 32'd0);

      // Overflow: 65536 does not fit in 16 bits
      sendDigit(4'd6);
      sendDigit(4'd5);
      sendDigit(4'd5);
      sendDigit(4'd3);
      checkOutput("ovf_pre_err", 32'(err), 32'd0);
      sendDigit(4'd6);
      checkOutput("ovf_err", 32'(err), 32'd1);
      checkOutput("ovf_code", 32'(err_code), 32'd1);
      checkOutput("ovf_vld", 32'(res_vld), 32'd0);
      sendOp(4'hE);
      checkOutput("ovf_clr_err", 32'(err), 32'd0);
      checkOutput("ovf_clr_code", 32'(err_code), 32'd0);

      // Digit limit: 123456 keeps only 12345
      sendDigit(4'd1);
      sendDigit(4'd2);
      sendDigit(4'd3);
      sendDigit(4'd4);
      sendDigit(4'd5);
      sendDigit(4'd6);
      checkOutput("lim_err", 32'(err), 32'd0);
      sendOp(4'h1);
      sendDigit(4'd1);
      sendOp(4'hF);
      checkOutput("lim_vld", 32'(res_vld), 32'd1);
      checkOutput("lim_a", 32'(operand_a), 32'd12345);
      checkOutput("lim_b", 32'(operand_b), 32'd1);
      idle();

      // Syntax: EQ as first token
      sendOp(4'hF);
      checkOutput("syn_eq_err", 32'(err), 32'd1);
      checkOutput("syn_eq_code", 32'(err_code), 32'd2);
      sendDigit(4'd3);
      checkOutput("syn_eq_sticky", 32'(err_code), 32'd2);
      recoverCheck("syn_eq");

      // Syntax: 4 =
      sendDigit(4'd4);
      sendOp(4'hF);
      checkOutput("syn_miss_code", 32'(err_code), 32'd2);
      checkOutput("syn_miss_vld", 32'(res_vld), 32'd0);
      recoverCheck("syn_miss");

      // Syntax: 4 op1 op2
      sendDigit(4'd4);
      sendOp(4'h1);
      sendOp(4'h2);
      checkOutput("syn_dbl_code", 32'(err_code), 32'd2);
      recoverCheck("syn_dbl");

      // Chained operator after the second operand
      sendDigit(4'd4);
      sendOp(4'h1);
      sendDigit(4'd5);
      sendOp(4'h2);
      checkOutput("syn_chain_code", 32'(err_code), 32'd2);
      recoverCheck("syn_chain");

      // Bad digit 0xA
      sendDigit(4'hA);
      checkOutput("bad_err", 32'(err), 32'd1);
      checkOutput("bad_code", 32'(err_code), 32'd3);
      recoverCheck("bad");

      // Simultaneous digit and op: digit 3 taken, op dropped
      applyStimulus(1'b1, 4'd3, 1'b1, 4'h1);
      sendOp(4'h2);
      sendDigit(4'd5);
      sendOp(4'hF);
      checkOutput("sim_err", 32'(err), 32'd0);
      checkOutput("sim_vld", 32'(res_vld), 32'd1);
      checkOutput("sim_a", 32'(operand_a), 32'd3);
      checkOutput("sim_op", 32'(operation), 32'd2);
      checkOutput("sim_b", 32'(operand_b), 32'd5);
      idle();

      // Abort: 8 op3 2 CLR, then a fresh 6 op1 7 =
      sendDigit(4'd8);
      sendOp(4'h3);
      sendDigit(4'd2);
      sendOp(4'hE);
      checkOutput("abort_vld", 32'(res_vld), 32'd0);
      checkOutput("abort_err", 32'(err), 32'd0);
      idle();
      checkOutput("abort_vld2", 32'(res_vld), 32'd0);
      sendDigit(4'd6);
      sendOp(4'h1);
      sendDigit(4'd7);
      sendOp(4'hF);
      checkOutput("abort_new_a", 32'(operand_a), 32'd6);
      checkOutput("abort_new_b", 32'(operand_b), 32'd7);
      idle();

      // Async reset in B_NUM, between clock edges
      sendDigit(4'd9);
      sendOp(4'h1);
      sendDigit(4'd9);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_a", 32'(operand_a), 32'd0);
      checkOutput("arst_b", 32'(operand_b), 32'd0);
      checkOutput("arst_op", 32'(operation), 32'd0);
      checkOutput("arst_vld", 32'(res_vld), 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_err", 32'(err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      sendDigit(4'd9);
      sendOp(4'h1);
      sendDigit(4'd9);
      sendOp(4'hF);
      checkOutput("arst_new_vld", 32'(res_vld), 32'd1);
      checkOutput("arst_new_a", 32'(operand_a), 32'd9);
      checkOutput("arst_new_b", 32'(operand_b), 32'd9);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/expr_parser_n.md
Name: expr_parser_n

Overview:
Parametrised expression front-end for the UART ALU path. It consumes a stream of decoded key tokens (decimal digits and operator codes). From that stream it builds two unsigned operands of configurable width and digit limit, plus one operator. It presents the result to the ALU over a valid/ready handshake and reports overflow and syntax errors.

Parameters:
W, 16, operand width in bits.
MAX_DIG, 5, maximum decimal digits accepted per operand (>=1).
OP_W, 4, operator code width.
OP_EQ, 4'hF, operator code meaning "equals", which terminates the expression.
OP_CLR, 4'hE, operator code meaning "clear", which aborts the expression or exits the error state.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
digit_i  in  4  decimal digit value
digit_vld  in  1  digit_i valid this cycle
op_i  in  OP_W  operator code
op_vld  in  1  op_i valid this cycle
operand_a  out  W  first operand
operand_b  out  W  second operand
operation  out  OP_W  latched operator
res_vld  out  1  operand_a/operand_b/operation valid
res_rdy  in  1  consumer accepts result
busy  out  1  high while a result is held awaiting res_rdy
err  out  1  sticky error flag
err_code  out  2  01 overflow, 10 syntax, 11 bad digit; 00 when err=0

Behaviour:
- Reset: all outputs 0. State goes to A_FIRST. Accumulators and digit counter are cleared. Reset asserted mid-operation discards all partial data immediately.
- Token acceptance:
  - One token is consumed per cycle.
  - If digit_vld and op_vld are both high in the same cycle, the digit is taken and the op is dropped.
  - Tokens arriving in the HOLD state are ignored.
  - Tokens arriving in the ERR state are ignored, except OP_CLR.
- OP_CLR in any state except HOLD: next state is A_FIRST. Accumulators, counter, err and err_code are cleared. res_vld stays 0.
- Digit accumulation:
  - Update rule: acc <= acc*10 + digit, computed at W+4 bits.
  - If the result exceeds 2^W-1: go to ERR, err_code=01.
  - If digit_i > 9: go to ERR, err_code=11.
  - The digit counter increments per accepted digit and saturates at MAX_DIG.
  - Digits after the MAX_DIG-th are ignored silently; the accumulator is unchanged and no error is raised.
- States:
  - A_FIRST:
    - digit -> acc_a=digit, cnt=1, go to A_NUM.
    - Any op other than CLR -> ERR, err_code=10.
  - A_NUM:
    - digit -> accumulate into acc_a.
    - OP_EQ -> ERR, err_code=10 (missing operator).
    - Any other op -> operation=op_i, cnt=0, go to B_FIRST.
  - B_FIRST:
    - digit -> acc_b=digit, cnt=1, go to B_NUM.
    - Any op other than CLR -> ERR, err_code=10.
  - B_NUM:
    - digit -> accumulate into acc_b.
    - OP_EQ -> go to HOLD.
    - Any other op -> ERR, err_code=10 (chained operators are not supported).
  - HOLD:
    - res_vld=1 and busy=1, starting the cycle after OP_EQ is accepted (latency 1).
    - operand_a, operand_b and operation stay stable while res_vld=1.
    - When res_vld && res_rdy at a rising edge: go to A_FIRST; res_vld and busy drop the next cycle.
    - res_rdy while res_vld=0 has no effect.
  - ERR:
    - err=1 and err_code held.
    - Only OP_CLR exits (to A_FIRST).
    - res_vld is never asserted from ERR.
- operand_a, operand_b and operation are driven from registers. Their values are only meaningful while res_vld=1.

Test Plan:
- Normal expression: tokens 1,2,op=4'h1,3,4,EQ, one per cycle, res_rdy=1 -> res_vld is high for exactly 1 cycle, the cycle after EQ; operand_a=12, operand_b=34, operation=1; err=0.
- Backpressure: tokens 7,op=2,5,EQ with res_rdy=0 for 3 cycles, and digit 9 injected while in HOLD -> res_vld and busy stay high 3+ cycles; operands 7/5 are unchanged; the 9 is ignored; state returns to A_FIRST one cycle after res_rdy=1.
- Overflow and digit limit (W=16):
  - A=6,5,5,3,6 -> err=1, err_code=01, no res_vld; OP_CLR then clears err.
  - A=1,2,3,4,5,6 -> operand_a=12345 (6th digit ignored).
- Syntax errors and bad digit:
  - EQ as the first token -> err_code=10.
  - 4,EQ -> err_code=10.
  - 4,op=1,op=2 -> err_code=10.
  - digit_i=4'hA -> err_code=11.
  - Recovery in each case: OP_CLR then 1,op=1,2,EQ -> valid result 1/2.
- Simultaneous tokens and abort:
  - digit_vld=1, digit=3 with op_vld=1, op=1 in the same cycle -> digit taken, op dropped.
  - 8,op=3,2,OP_CLR -> no res_vld, state A_FIRST.
- Async reset: assert rst mid-B_NUM between clock edges -> all outputs 0 immediately; after release, a new expression 9,op=1,9,EQ gives operand_a=9 and operand_b=9.
